pc_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch: issues one request at a time
//  to word-addressed instruction memory, presents the fetched word to decode with a

---
 rtl/rv_core_pkg.sv | 16 +
 rtl/pc_next_gen.sv | 22 ++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core constants and the fetch sequencer state type.
package rv_core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = XLEN'(0);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(1);

  typedef enum logic [2:0] {
    PCSEQ_IDLE  = 3'd0,
    PCSEQ_REQ   = 3'd1,
    PCSEQ_WAIT  = 3'd2,
    PCSEQ_HOLD  = 3'd3,
    PCSEQ_DRAIN = 3'd4
  } pcseq_state_t;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC selection: redirect target beats sequential advance, otherwise hold.
module pc_next_gen
  import rv_core_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic            advance_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_next_c
);

  // Addition wraps modulo 2^XLEN with no overflow indication.
  always_comb begin
    pc_next_c = pc_i;
    if (redirect_i) begin
      pc_next_c = redirect_pc_i;
    end else if (advance_i) begin
      pc_next_c = pc_i + PC_INC;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
// Optional stall counter output bp_cycles enabled by defining PCSEQ_PERF_CNT_EN.
module pc_sequencer
  import rv_core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef PCSEQ_PERF_CNT_EN
  ,
  output logic [31:0]     bp_cycles
`endif
);

  pcseq_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] ifpc_q, ifpc_d;
  logic            advance;
  logic            xfer;

  assign xfer = valid_q & id_ready;

  pc_next_gen u_pc_next_gen (
    .pc_i          (pc_q),
    .advance_i     (advance),
    .redirect_i    (redirect_valid),
    .redirect_pc_i (redirect_pc),
    .pc_next_c     (pc_d)
  );

  // A redirect kills any in-flight fetch; DRAIN absorbs its response.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    advance = 1'b0;
    case (state_q)
      PCSEQ_IDLE: state_d = PCSEQ_REQ;
      PCSEQ_REQ: begin
        if (imem_gnt) begin
          state_d = redirect_valid ? PCSEQ_DRAIN : PCSEQ_WAIT;
        end
      end
      PCSEQ_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            state_d = PCSEQ_REQ;
          end else begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            state_d = PCSEQ_HOLD;
          end
        end else if (redirect_valid) begin
          state_d = PCSEQ_DRAIN;
        end
      end
      PCSEQ_HOLD: begin
        if (redirect_valid || xfer) begin
          valid_d = 1'b0;
          advance = xfer;
          state_d = PCSEQ_REQ;
        end
      end
      PCSEQ_DRAIN: begin
        if (imem_rvalid) begin
          state_d = PCSEQ_REQ;
        end
      end
      default: state_d = PCSEQ_IDLE;
    endcase
    req_d = (state_d == PCSEQ_REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PCSEQ_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;

`ifdef PCSEQ_PERF_CNT_EN
  logic [31:0] bp_q;

  // Saturating count of cycles where decode stalls a held instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_q <= 32'd0;
    end else if (valid_q && !id_ready && (bp_q != 32'hFFFF_FFFF)) begin
      bp_q <= bp_q + 32'd1;
    end
  end

  assign bp_cycles = bp_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner sequences, random run.
module tb_pc_sequencer;
  import rv_core_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
`ifdef PCSEQ_PERF_CNT_EN
  logic [31:0] bp_cycles;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef PCSEQ_PERF_CNT_EN
    ,
    .bp_cycles      (bp_cycles)
`endif
  );

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl[NV];

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] fdata(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic g, input logic rv, input logic [31:0] d, input logic rdy,
                     input logic rd, input logic [31:0] rpc);
    imem_gnt       = g;
    imem_rvalid    = rv;
    imem_rdata     = d;
    id_ready       = rdy;
    redirect_valid = rd;
    redirect_pc    = rpc;
  endtask

  task automatic setv(input int i, input logic g, input logic rv, input logic [31:0] d,
                      input logic rdy, input logic rd, input logic [31:0] rpc,
                      input logic er, input logic [31:0] ea, input logic ev,
                      input logic [31:0] ep, input logic [31:0] ei);
    tbl[i].gnt = g;  tbl[i].rv = rv;  tbl[i].rdata = d;  tbl[i].rdy = rdy;
    tbl[i].rd = rd;  tbl[i].rpc = rpc;
    tbl[i].e_req = er;  tbl[i].e_addr = ea;  tbl[i].e_valid = ev;
    tbl[i].e_pc = ep;  tbl[i].e_instr = ei;
  endtask

  // Leaves the bench at the negedge where the sequencer first sits in its request state.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b0;
    drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk({tag, "_rst_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_rst_addr"}, imem_addr, RESET_PC);
    chk({tag, "_rst_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_rst_instr"}, if_instr, 32'd0);
    chk({tag, "_rst_pc"}, if_pc, RESET_PC);
`ifdef PCSEQ_PERF_CNT_EN
    chk({tag, "_rst_bp"}, bp_cycles, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
  endtask

  logic        m_valid, out_busy, out_kill, g, rv, rdy, rdr, xfer;
  logic [31:0] m_pc, m_instr, m_pcv, out_addr, rpc;
  int          out_dly;
  int          m_bp;

  initial begin
    // Basic fetch stream, then redirects in WAIT, REQ, DRAIN and HOLD.
    setv(0,  1, 0, 0,           1, 0, 0,     1, 0,     0, 0,     0);
    setv(1,  0, 1, fdata(0),    1, 0, 0,     0, 0,     0, 0,     0);
    setv(2,  0, 0, 0,           1, 0, 0,     0, 0,     1, 0,     fdata(0));
    setv(3,  1, 0, 0,           1, 0, 0,     1, 1,     0, 0,     0);
    setv(4,  0, 1, fdata(1),    1, 0, 0,     0, 1,     0, 0,     0);
    setv(5,  0, 0, 0,           1, 0, 0,     0, 1,     1, 1,     fdata(1));
    setv(6,  1, 0, 0,           1, 0, 0,     1, 2,     0, 0,     0);
    setv(7,  0, 1, fdata(2),    1, 0, 0,     0, 2,     0, 0,     0);
    setv(8,  0, 0, 0,           1, 0, 0,     0, 2,     1, 2,     fdata(2));
    setv(9,  1, 0, 0,           1, 0, 0,     1, 3,     0, 0,     0);
    setv(10, 0, 0, 0,           1, 1, 'h40,  0, 3,     0, 0,     0);
    setv(11, 0, 0, 0,           1, 0, 0,     0, 'h40,  0, 0,     0);
    setv(12, 0, 1, 'hDEADBEEF,  1, 0, 0,     0, 'h40,  0, 0,     0);
    setv(13, 1, 0, 0,           1, 0, 0,     1, 'h40,  0, 0,     0);
    setv(14, 0, 1, fdata('h40), 1, 1, 'h80,  0, 'h40,  0, 0,     0);
    setv(15, 1, 0, 0,           1, 1, 'h90,  1, 'h80,  0, 0,     0);
    setv(16, 0, 1, 'hBAD0BAD0,  1, 0, 0,     0, 'h90,  0, 0,     0);
    setv(17, 0, 0, 0,           1, 1, 'hA0,  1, 'h90,  0, 0,     0);
    setv(18, 1, 0, 0,           1, 0, 0,     1, 'hA0,  0, 0,     0);
    setv(19, 0, 1, fdata('hA0), 1, 0, 0,     0, 'hA0,  0, 0,     0);
    setv(20, 0, 0, 0,           0, 1, 'hB0,  0, 'hA0,  1, 'hA0, fdata('hA0));
    setv(21, 1, 0, 0,           1, 0, 0,     1, 'hB0,  0, 0,     0);
    setv(22, 0, 1, fdata('hB0), 1, 0, 0,     0, 'hB0,  0, 0,     0);
    setv(23, 0, 0, 0,           1, 1, 'hC0,  0, 'hB0,  1, 'hB0, fdata('hB0));
    setv(24, 0, 0, 0,           1, 0, 0,     1, 'hC0,  0, 0,     0);
    setv(25, 0, 0, 0,           1, 0, 0,     1, 'hC0,  0, 0,     0);

    do_reset("tbl");
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_ifpc", i), if_pc, tbl[i].e_pc);
        chk($sformatf("vec%0d_instr", i), if_instr, tbl[i].e_instr);
      end
      drv(tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].rdy, tbl[i].rd, tbl[i].rpc);
      @(negedge clk);
    end

    // Back-pressure: five stalled cycles in HOLD keep the instruction and suppress requests.
    do_reset("bp");
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drv(0, 1, fdata(0), 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(if_valid), 32'd1);
      chk($sformatf("bp%0d_instr", k), if_instr, fdata(0));
      chk($sformatf("bp%0d_req", k), 32'(imem_req), 32'd0);
      drv(0, 0, 0, 0, 0, 0);
      @(negedge clk);
    end
    chk("bp_valid_end", 32'(if_valid), 32'd1);
`ifdef PCSEQ_PERF_CNT_EN
    chk("bp_cycles", bp_cycles, 32'd5);
`endif
    drv(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("bp_next_req", 32'(imem_req), 32'd1);
    chk("bp_next_addr", imem_addr, 32'd1);

    // PC wraps from all-ones to zero on a sequential advance.
    do_reset("wrap");
    drv(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFF);
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    drv(0, 1, fdata(32'hFFFF_FFFF), 0, 0, 0);
    @(negedge clk);
    chk("wrap_ifpc", if_pc, 32'hFFFF_FFFF);
    drv(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("wrap_req", 32'(imem_req), 32'd1);
    chk("wrap_addr", imem_addr, 32'd0);

    // Reset in WAIT, then a stale response after release must be ignored.
    do_reset("mid");
    drv(0, 0, 0, 0, 1, 32'h55);
    @(negedge clk);
    drv(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_wait_req", 32'(imem_req), 32'd0);
    chk("mid_wait_addr", imem_addr, 32'h55);
    drv(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("mid_async_addr", imem_addr, RESET_PC);
    @(negedge clk);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    reset = 1'b1;
    drv(0, 1, 32'hCAFE_F00D, 1, 0, 0);
    @(negedge clk);
    chk("mid_post_req", 32'(imem_req), 32'd1);
    chk("mid_post_valid", 32'(if_valid), 32'd0);
    drv(0, 1, 32'hCAFE_F00D, 1, 0, 0);
    @(negedge clk);
    chk("mid_post2_req", 32'(imem_req), 32'd1);
    chk("mid_post2_valid", 32'(if_valid), 32'd0);
    chk("mid_post2_addr", imem_addr, RESET_PC);

    // Random run against a transaction-level model of the fetch protocol.
    do_reset("rnd");
    m_pc = RESET_PC; m_valid = 1'b0; m_instr = 32'd0; m_pcv = 32'd0;
    out_busy = 1'b0; out_kill = 1'b0; out_addr = 32'd0; out_dly = 0; m_bp = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_req", 32'(imem_req), 32'(!out_busy && !m_valid));
      chk("rnd_valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rnd_ifpc", if_pc, m_pcv);
        chk("rnd_instr", if_instr, m_instr);
      end
      if (imem_req) chk("rnd_addr", imem_addr, m_pc);
      g   = imem_req && ($urandom_range(0, 2) != 0);
      rv  = out_busy && (out_dly == 0);
      rdy = ($urandom_range(0, 3) != 0);
      rdr = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 255));
      drv(g, rv, rv ? fdata(out_addr) : $urandom, rdy, rdr, rpc);
      xfer = m_valid && rdy;
      if (m_valid && !rdy) m_bp++;
      if (rv) begin
        if (!(out_kill || rdr)) begin
          m_valid = 1'b1;
          m_instr = fdata(out_addr);
          m_pcv   = out_addr;
        end
        out_busy = 1'b0;
      end else if (m_valid && (xfer || rdr)) begin
        m_valid = 1'b0;
      end
      if (out_busy) begin
        if (rdr) out_kill = 1'b1;
        out_dly--;
      end
      if (g) begin
        out_busy = 1'b1;
        out_addr = m_pc;
        out_kill = rdr;
        out_dly  = int'($urandom_range(0, 2));
      end
      if (rdr) m_pc = rpc;
      else if (xfer) m_pc = m_pc + 32'd1;
      @(negedge clk);
    end
`ifdef PCSEQ_PERF_CNT_EN
    chk("rnd_bp", bp_cycles, 32'(m_bp));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
